// File: rtl/mvau_stream_ctrl_fsm.sv
// MVAU stream controller: folds one SF-beat input vector through NF filter-bank
// passes, driving buffer/weight addresses, accumulator strobes and result valid.
module mvau_stream_ctrl_fsm #(
    parameter int SF           = 8,
    parameter int NF           = 4,
    parameter int WMEM_DEPTH   = SF * NF,
    parameter int WMEM_ADDR_BW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1,
    parameter int SF_BW        = (SF > 1) ? $clog2(SF) : 1,
    parameter int PIPE_LAT     = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    in_v_i,
    output logic                    in_rdy_o,
    input  logic                    out_rdy_i,
    output logic                    out_v_o,
    output logic                    inbuf_wr_en_o,
    output logic [SF_BW-1:0]        inbuf_wr_addr_o,
    output logic [SF_BW-1:0]        inbuf_rd_addr_o,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr_o,
    output logic                    mac_en_o,
    output logic                    acc_clr_o,
    output logic                    acc_last_o,
    output logic                    busy_o
);

    localparam int NF_BW = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SF_BW-1:0]        SF_LAST   = SF_BW'(SF - 1);
    localparam logic [NF_BW-1:0]        NF_LAST   = NF_BW'(NF - 1);
    localparam logic [WMEM_ADDR_BW-1:0] WMEM_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    if (WMEM_DEPTH != SF * NF) begin : g_depth_chk
        $error("mvau_stream_ctrl_fsm: WMEM_DEPTH must equal SF*NF");
    end

    typedef enum logic {
        FILL  = 1'b0,
        REUSE = 1'b1
    } state_e;

    state_e                  state_q;
    logic [SF_BW-1:0]        sf_cnt_q;
    logic [NF_BW-1:0]        nf_cnt_q;
    logic [WMEM_ADDR_BW-1:0] wmem_addr_q;
    logic [PIPE_LAT-1:0]     pipe_q;

    logic out_v, stall, fill, in_rdy, beat, sf_wrap, last;

    // Every handshake output is forced low while reset is held, even before the edge.
    assign out_v   = aresetn & pipe_q[PIPE_LAT-1];
    assign stall   = out_v & ~out_rdy_i;
    assign fill    = (state_q == FILL);
    assign in_rdy  = aresetn & fill & ~stall;
    assign beat    = aresetn & (fill ? (in_v_i & in_rdy) : ~stall);
    assign sf_wrap = (sf_cnt_q == SF_LAST);
    assign last    = beat & sf_wrap;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= FILL;
            sf_cnt_q    <= '0;
            nf_cnt_q    <= '0;
            wmem_addr_q <= '0;
            pipe_q      <= '0;
        end else begin
            if (beat) begin
                sf_cnt_q    <= sf_wrap ? '0 : sf_cnt_q + SF_BW'(1);
                wmem_addr_q <= (wmem_addr_q == WMEM_LAST) ? '0 : wmem_addr_q + WMEM_ADDR_BW'(1);
                if (sf_wrap) begin
                    nf_cnt_q <= (nf_cnt_q == NF_LAST) ? '0 : nf_cnt_q + NF_BW'(1);
                    if (state_q == FILL && NF > 1) begin
                        state_q <= REUSE;
                    end else if (state_q == REUSE && nf_cnt_q == NF_LAST) begin
                        state_q <= FILL;
                    end
                end
            end
            // Result pipeline freezes with the downstream so a held out_v is never lost.
            if (!stall) begin
                pipe_q[0] <= last;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end
    end

    assign in_rdy_o        = in_rdy;
    assign out_v_o         = out_v;
    assign mac_en_o        = beat;
    assign inbuf_wr_en_o   = beat & fill;
    assign inbuf_wr_addr_o = sf_cnt_q;
    assign inbuf_rd_addr_o = sf_cnt_q;
    assign wmem_addr_o     = wmem_addr_q;
    assign acc_clr_o       = beat & (sf_cnt_q == '0);
    assign acc_last_o      = last;
    assign busy_o          = (sf_cnt_q != '0) | (nf_cnt_q != '0) | (|pipe_q);

endmodule

// File: tb/tb_mvau_stream_ctrl_fsm.sv
// Scoreboard bench for mvau_stream_ctrl_fsm: SF=4/NF=3 instance under random
// stimulus plus an SF=1/NF=1 instance for the degenerate fold case.
module tb_mvau_stream_ctrl_fsm;
    localparam int SF0 = 4;
    localparam int NF0 = 3;
    localparam int PL0 = 2;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic       aresetn = 1'b0, in_v = 1'b0, out_rdy = 1'b1;
    logic       in_rdy0, out_v0, wr_en0, mac_en0, clr0, last0, busy0;
    logic [1:0] wr_addr0, rd_addr0;
    logic [3:0] wmem0;

    mvau_stream_ctrl_fsm #(.SF(SF0), .NF(NF0), .PIPE_LAT(PL0)) dut0 (
        .aclk(aclk), .aresetn(aresetn), .in_v_i(in_v), .in_rdy_o(in_rdy0),
        .out_rdy_i(out_rdy), .out_v_o(out_v0), .inbuf_wr_en_o(wr_en0),
        .inbuf_wr_addr_o(wr_addr0), .inbuf_rd_addr_o(rd_addr0), .wmem_addr_o(wmem0),
        .mac_en_o(mac_en0), .acc_clr_o(clr0), .acc_last_o(last0), .busy_o(busy0)
    );

    logic rst1 = 1'b0, in_v1 = 1'b0, out_rdy1 = 1'b1;
    logic in_rdy1, out_v1, wr_en1, mac_en1, clr1, last1, busy1;
    logic wr_addr1, rd_addr1, wmem1;

    mvau_stream_ctrl_fsm #(.SF(1), .NF(1), .PIPE_LAT(2)) dut1 (
        .aclk(aclk), .aresetn(rst1), .in_v_i(in_v1), .in_rdy_o(in_rdy1),
        .out_rdy_i(out_rdy1), .out_v_o(out_v1), .inbuf_wr_en_o(wr_en1),
        .inbuf_wr_addr_o(wr_addr1), .inbuf_rd_addr_o(rd_addr1), .wmem_addr_o(wmem1),
        .mac_en_o(mac_en1), .acc_clr_o(clr1), .acc_last_o(last1), .busy_o(busy1)
    );

    typedef struct {
        int wmem;
        bit clr;
        bit last;
        bit wr;
    } beat_t;

    typedef struct {
        bit in_rdy;
        bit out_v;
        bit busy;
        int wmem;
        int addr;
    } cyc_t;

    beat_t beat_q[$];
    cyc_t  cyc_q[$];
    int    out_q[$];
    int    pend_q[$];   // remaining unstalled cycles before each pending row result shows
    int    k = 0;       // position of the next beat inside the SF*NF schedule
    int    n_rows = 0;
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst_n, input bit v, input bit ordy);
        bit exp_outv, stall, fill, exp_rdy, beat;
        int sf;
        cyc_t  c;
        beat_t b;
        @(posedge aclk);
        #1;
        aresetn = rst_n;
        in_v    = v;
        out_rdy = ordy;
        exp_outv = rst_n && pend_q.size() > 0 && pend_q[0] == 0;
        stall    = exp_outv && !ordy;
        fill     = (k < SF0);
        exp_rdy  = rst_n && fill && !stall;
        beat     = rst_n && (fill ? (v && exp_rdy) : !stall);
        sf       = k % SF0;
        c.in_rdy = exp_rdy;
        c.out_v  = exp_outv;
        c.busy   = (k != 0) || (pend_q.size() > 0);
        c.wmem   = k;
        c.addr   = sf;
        cyc_q.push_back(c);
        if (beat) begin
            b.wmem = k;
            b.clr  = (sf == 0);
            b.last = (sf == SF0 - 1);
            b.wr   = fill;
            beat_q.push_back(b);
        end
        if (!rst_n) begin
            k = 0;
            pend_q.delete();
            out_q.delete();
        end else begin
            if (!stall) begin
                if (exp_outv) void'(pend_q.pop_front());
                foreach (pend_q[i]) if (pend_q[i] > 0) pend_q[i]--;
            end
            if (beat) begin
                if (sf == SF0 - 1) begin
                    pend_q.push_back(PL0 - 1);
                    out_q.push_back(n_rows);
                    n_rows++;
                end
                k = (k + 1) % (SF0 * NF0);
            end
        end
    endtask

    // Monitor for dut0: pops the per-cycle and per-beat expectations at negedge.
    initial begin
        cyc_t  c;
        beat_t b;
        forever begin
            @(negedge aclk);
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                chk("in_rdy", int'(in_rdy0), int'(c.in_rdy));
                chk("out_v", int'(out_v0), int'(c.out_v));
                chk("busy", int'(busy0), int'(c.busy));
                chk("wmem_addr", int'(wmem0), c.wmem);
                chk("inbuf_rd_addr", int'(rd_addr0), c.addr);
                chk("inbuf_wr_addr", int'(wr_addr0), c.addr);
                if (mac_en0) begin
                    n_cmp++;
                    if (beat_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: got mac_en=1 expected 0 at %0t", $time);
                    end else begin
                        b = beat_q.pop_front();
                        chk("beat_wmem", int'(wmem0), b.wmem);
                        chk("acc_clr", int'(clr0), int'(b.clr));
                        chk("acc_last", int'(last0), int'(b.last));
                        chk("inbuf_wr_en", int'(wr_en0), int'(b.wr));
                    end
                end else begin
                    chk("idle_acc_clr", int'(clr0), 0);
                    chk("idle_acc_last", int'(last0), 0);
                    chk("idle_wr_en", int'(wr_en0), 0);
                end
                chk("missed_beat", beat_q.size(), 0);
                beat_q.delete();
                if (out_v0 && out_rdy) begin
                    n_cmp++;
                    if (out_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_result: got out_v accepted expected none at %0t", $time);
                    end else begin
                        void'(out_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic run_dut0();
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (30) step(1'b1, 1'b1, 1'b1);
        repeat (500) step(1'b1, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        repeat (8) step(1'b1, 1'b1, 1'b0);
        repeat (400) step($urandom_range(0, 59) != 0, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) < 7);
        repeat (30) step(1'b1, 1'b1, 1'b1);
        repeat (25) step(1'b1, 1'b0, 1'b1);
        @(negedge aclk);
        @(negedge aclk);
        chk("results_outstanding", out_q.size(), 0);
        chk("rows_seen_nonzero", int'(n_rows > 20), 1);
    endtask

    task automatic run_dut1();
        bit b1 = 0, b2 = 0, bt;
        repeat (2) @(posedge aclk);
        #1 rst1 = 1'b1;
        repeat (60) begin
            @(posedge aclk);
            #1 in_v1 = ($urandom_range(0, 3) != 0);
            @(negedge aclk);
            bt = in_v1;
            chk("sf1_in_rdy", int'(in_rdy1), 1);
            chk("sf1_mac_en", int'(mac_en1), int'(bt));
            chk("sf1_acc_clr", int'(clr1), int'(bt));
            chk("sf1_acc_last", int'(last1), int'(bt));
            chk("sf1_wmem_addr", int'(wmem1), 0);
            chk("sf1_out_v", int'(out_v1), int'(b2));
            b2 = b1;
            b1 = bt;
        end
    endtask

    initial begin
        fork
            run_dut0();
            run_dut1();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
